// File: rtl/cache_fill_ctrl.sv
// Miss-fill sequencer for the 2-way cache data array (8 x 16-bit words per block).
// Define CRITICAL_WORD_FIRST_EN to fetch the missing word first and expose critical_valid.
module cache_fill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              miss_way,
    input  logic              memory_data_valid,
    input  logic [15:0]       memory_data,
    output logic              fsm_busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] memory_address,
    output logic [15:0]       data_in,
    output logic [1:0]        data_write,
    output logic [63:0]       block_enable,
    output logic [WORDS-1:0]  word_enable,
    output logic              tag_write,
`ifdef CRITICAL_WORD_FIRST_EN
    output logic              critical_valid,
`endif
    output logic              fill_done
);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-5:0]   tag_q;
    logic                way_q;
    logic [2:0]          issue_cnt_q;
    logic [2:0]          recv_cnt_q;
    logic                req_q;
    logic                busy_q;
    logic [63:0]         blk_q;
    logic [2:0]          issue_idx;
    logic [2:0]          recv_idx;
    logic                wr;
    logic                last;

`ifdef CRITICAL_WORD_FIRST_EN
    logic [2:0]          word_q;
    logic                unused_addr;

    assign unused_addr = miss_address[0];
    assign issue_idx   = word_q + issue_cnt_q;
    assign recv_idx    = word_q + recv_cnt_q;
`else
    logic                unused_addr;

    assign unused_addr = ^miss_address[3:0];
    assign issue_idx   = issue_cnt_q;
    assign recv_idx    = recv_cnt_q;
`endif

    assign wr   = (state_q == FILL) && memory_data_valid;
    assign last = wr && (recv_cnt_q == 3'd7);

    // req_q doubles as the "issues outstanding" flag: it drops after the 8th issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tag_q       <= '0;
            way_q       <= 1'b0;
            issue_cnt_q <= 3'd0;
            recv_cnt_q  <= 3'd0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            blk_q       <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            word_q      <= 3'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_detected) begin
                        state_q     <= FILL;
                        tag_q       <= miss_address[ADDR_W-1:4];
                        way_q       <= miss_way;
                        issue_cnt_q <= 3'd0;
                        recv_cnt_q  <= 3'd0;
                        req_q       <= 1'b1;
                        busy_q      <= 1'b1;
                        blk_q       <= 64'd1 << miss_address[9:4];
`ifdef CRITICAL_WORD_FIRST_EN
                        word_q      <= miss_address[3:1];
`endif
                    end
                end
                FILL: begin
                    if (req_q) begin
                        issue_cnt_q <= issue_cnt_q + 3'd1;
                        if (issue_cnt_q == 3'd7) begin
                            req_q <= 1'b0;
                        end
                    end
                    if (wr) begin
                        recv_cnt_q <= recv_cnt_q + 3'd1;
                    end
                    if (last) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        blk_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fsm_busy       = busy_q;
    assign block_enable   = blk_q;
    assign mem_req        = req_q;
    assign memory_address = req_q ? {tag_q, issue_idx, 1'b0} : '0;
    assign data_in        = memory_data;
    assign data_write     = wr ? (way_q ? 2'b10 : 2'b01) : 2'b00;
    assign word_enable    = wr ? (WORDS'(1) << recv_idx) : '0;
    assign tag_write      = last;
    assign fill_done      = last;
`ifdef CRITICAL_WORD_FIRST_EN
    assign critical_valid = wr && (recv_cnt_q == 3'd0);
`endif

endmodule
